// File: rtl/ram.sv
// ram -- single-clock word memory with registered, write-first read port
// and a post-reset clear sequencer that zeroes one word per cycle.
// Optional build macro RAM_PARITY_EN adds one even-parity bit per stored
// word and a registered parity_error output aligned with data_read.
module ram #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 5,
   parameter int A_MAX   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               write_enable,
   input  logic [A_WIDTH-1:0] address_write,
   input  logic [D_WIDTH-1:0] data_write,
   input  logic [A_WIDTH-1:0] address_read,
`ifdef RAM_PARITY_EN
   output logic               parity_error,
`endif
   output logic [D_WIDTH-1:0] data_read,
   output logic               init_busy
);

`ifdef RAM_PARITY_EN
   localparam int P_BITS = 1;
`else
   localparam int P_BITS = 0;
`endif
   localparam int M_WIDTH = D_WIDTH + P_BITS;

   // One extra bit so that A_MAX == 2**A_WIDTH is representable.
   localparam logic [A_WIDTH:0] A_LIMIT = (A_WIDTH+1)'(A_MAX);
   localparam logic [A_WIDTH:0] A_LAST  = A_LIMIT - 1'b1;

   logic [M_WIDTH-1:0] mem_q [A_MAX];

   logic [A_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
   logic               init_busy_q, init_busy_d;
   logic [D_WIDTH-1:0] data_read_q;
`ifdef RAM_PARITY_EN
   logic               parity_error_q;
`endif

   logic               wr_in_range;
   logic               rd_in_range;
   logic               user_wr;
   logic               mem_we;
   logic [A_WIDTH-1:0] mem_wa;
   logic [M_WIDTH-1:0] mem_wd;

   assign wr_in_range = ({1'b0, address_write} < A_LIMIT);
   assign rd_in_range = ({1'b0, address_read} < A_LIMIT);
   // A user write only lands once clearing is done and the address exists.
   assign user_wr     = write_enable && !init_busy_q && wr_in_range;

   // Clear sequencer next state: walk 0..A_MAX-1, drop busy on the last word.
   always_comb begin
      clr_ptr_d   = clr_ptr_q;
      init_busy_d = init_busy_q;
      if (init_busy_q) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if ({1'b0, clr_ptr_q} == A_LAST) begin
            init_busy_d = 1'b0;
         end
      end
   end

   // Sequencer state; reset restarts the whole clear from address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_ptr_q   <= '0;
         init_busy_q <= 1'b1;
      end else begin
         clr_ptr_q   <= clr_ptr_d;
         init_busy_q <= init_busy_d;
      end
   end

   // Single write port shared by the clear sequencer and user writes.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = address_write;
      mem_wd = '0;
      if (!rst) begin
         if (init_busy_q) begin
            // Cleared words carry zero data and a zero parity bit.
            mem_we = 1'b1;
            mem_wa = clr_ptr_q;
            mem_wd = '0;
         end else if (user_wr) begin
            mem_we = 1'b1;
`ifdef RAM_PARITY_EN
            mem_wd = {^data_write, data_write};
`else
            mem_wd = data_write;
`endif
         end
      end
   end

   // Storage array: no reset, so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   // Registered read: zero while reset/busy/out of range, write-first bypass
   // on a same-address write, otherwise the stored word.
   always_ff @(posedge clk) begin
      if (rst || init_busy_q || !rd_in_range) begin
         data_read_q <= '0;
`ifdef RAM_PARITY_EN
         parity_error_q <= 1'b0;
`endif
      end else if (user_wr && (address_write == address_read)) begin
         data_read_q <= data_write;
`ifdef RAM_PARITY_EN
         parity_error_q <= 1'b0;
`endif
      end else begin
         data_read_q <= mem_q[address_read][D_WIDTH-1:0];
`ifdef RAM_PARITY_EN
         // Even parity: XOR over data plus stored bit must be zero.
         parity_error_q <= ^mem_q[address_read];
`endif
      end
   end

   assign data_read = data_read_q;
   assign init_busy = init_busy_q;
`ifdef RAM_PARITY_EN
   assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_ram.sv
// tb_ram -- drives a 32-word and a 24-word ram with the same stimulus and
// checks both against an array-based model every cycle, plus literal checks.
module tb_ram;

  logic       clk;
  logic       rst;
  logic       we;
  logic [4:0] wa;
  logic [7:0] wd;
  logic [4:0] ra;
  logic [7:0] rd32, rd24;
  logic       busy32, busy24;
`ifdef RAM_PARITY_EN
  logic       perr32, perr24;
`endif

  int errors = 0;
  int checks = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram #(8, 5, 32) u32 (
    .clk(clk), .rst(rst), .write_enable(we), .address_write(wa),
    .data_write(wd), .address_read(ra),
`ifdef RAM_PARITY_EN
    .parity_error(perr32),
`endif
    .data_read(rd32), .init_busy(busy32)
  );

  ram #(8, 5, 24) u24 (
    .clk(clk), .rst(rst), .write_enable(we), .address_write(wa),
    .data_write(wd), .address_read(ra),
`ifdef RAM_PARITY_EN
    .parity_error(perr24),
`endif
    .data_read(rd24), .init_busy(busy24)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: array per memory size, busy as remaining clear words
  int         amax [2] = '{32, 24};
  logic [7:0] m_mem [2][32];
  int         busy_left [2];
  logic [7:0] exp_rd [2];
  logic       exp_busy [2];
  bit         model_valid = 0;
  bit         chk_en = 1;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy_left[k] = amax[k];
        exp_rd[k]    = 8'h00;
        exp_busy[k]  = 1'b1;
      end else if (busy_left[k] > 0) begin
        m_mem[k][amax[k] - busy_left[k]] = 8'h00;
        busy_left[k]--;
        exp_busy[k] = (busy_left[k] != 0);
        exp_rd[k]   = 8'h00;
      end else begin
        if (we && int'(wa) < amax[k]) m_mem[k][wa] = wd;
        exp_rd[k]   = (int'(ra) < amax[k]) ? m_mem[k][ra] : 8'h00;
        exp_busy[k] = 1'b0;
      end
    end
    if (rst) model_valid = 1;
  end

  // compare process, sampled 2 time units after the active edge
  always @(posedge clk) begin
    #2;
    if (model_valid && chk_en) begin
      chk("cyc_rd32", rd32, exp_rd[0]);
      chk("cyc_busy32", {7'd0, busy32}, {7'd0, exp_busy[0]});
      chk("cyc_rd24", rd24, exp_rd[1]);
      chk("cyc_busy24", {7'd0, busy24}, {7'd0, exp_busy[1]});
`ifdef RAM_PARITY_EN
      chk("cyc_perr32", {7'd0, perr32}, 8'h00);
      chk("cyc_perr24", {7'd0, perr24}, 8'h00);
`endif
    end
  end

  // driver: inputs change on the falling edge; returns after the next
  // rising edge has been absorbed (at the following falling edge)
  task automatic cyc(input logic r, input logic w, input logic [4:0] a,
                     input logic [7:0] d, input logic [4:0] rda);
    rst = r; we = w; wa = a; wd = d; ra = rda;
    @(negedge clk);
  endtask

  int cnt32, cnt24;

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    chk("rst_rd32", rd32, 8'h00);
    chk("rst_busy32", {7'd0, busy32}, 8'h01);
    chk("rst_busy24", {7'd0, busy24}, 8'h01);

    // clear length after reset release: 32 and 24 cycles
    cnt32 = 0; cnt24 = 0;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy32) cnt32++;
      if (busy24) cnt24++;
      cyc(0, 0, 0, 0, 0);
    end
    chk("clear_len32", 8'(cnt32), 8'd32);
    chk("clear_len24", 8'(cnt24), 8'd24);

    cyc(0, 0, 0, 0, 5'h1B);
    chk("read_cleared_1b", rd32, 8'h00);

    cyc(0, 1, 5'h1B, 8'hC5, 5'h00);
    cyc(0, 0, 0, 0, 5'h1B);
    chk("wr_rd_1b_32", rd32, 8'hC5);
    chk("wr_rd_1b_24_oor", rd24, 8'h00);

    cyc(0, 1, 5'h04, 8'h3A, 5'h04);
    chk("bypass_04_32", rd32, 8'h3A);
    chk("bypass_04_24", rd24, 8'h3A);

    cyc(0, 1, 5'h1B, 8'hFF, 5'h1B);
    chk("oor_bypass_24", rd24, 8'h00);
    chk("bypass_1b_32", rd32, 8'hFF);
    cyc(0, 1, 5'h17, 8'h11, 5'h00);
    cyc(0, 0, 0, 0, 5'h17);
    chk("last_word_24", rd24, 8'h11);

    cyc(0, 1, 5'h05, 8'hAA, 5'h04);
    chk("indep_rd04", rd32, 8'h3A);

    // reset mid-operation restarts clear; writes during busy are lost
    cyc(0, 1, 5'h1B, 8'hC5, 5'h00);
    cnt32 = 0; cnt24 = 0;
    cyc(1, 0, 0, 0, 0);
    if (busy32) cnt32++;
    if (busy24) cnt24++;
    for (int i = 0; i < 40; i++) begin
      cyc(0, (i < 20), 5'h02, 8'h77, 5'h1B);
      if (busy32) cnt32++;
      if (busy24) cnt24++;
    end
    chk("reclear_len32", 8'(cnt32), 8'd32);
    chk("reclear_len24", 8'(cnt24), 8'd24);
    cyc(0, 0, 0, 0, 5'h1B);
    chk("reclear_1b", rd32, 8'h00);
    cyc(0, 0, 0, 0, 5'h02);
    chk("busy_write_lost", rd32, 8'h00);

`ifdef RAM_PARITY_EN
    cyc(0, 1, 5'h1B, 8'hC5, 5'h00);
    chk_en = 0;
    u32.mem_q[27][0] = ~u32.mem_q[27][0];
    cyc(0, 0, 0, 0, 5'h1B);
    chk("perr_flipped", {7'd0, perr32}, 8'h01);
    cyc(0, 0, 0, 0, 5'h04);
    chk("perr_clean", {7'd0, perr32}, 8'h00);
    cyc(0, 1, 5'h1B, 8'hC5, 5'h00);
    chk_en = 1;
`endif

    // randomized phase with occasional resets
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) != 0),
          5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
          5'($urandom_range(0, 31)));
    end

    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 The block SHALL have positional parameter 1: D_WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have positional parameter 2: A_WIDTH, default 5, address width in bits.
REQ-003 The block SHALL have positional parameter 3: A_MAX, default 32, number of words, legal range 1..2^A_WIDTH.
REQ-004 The block SHALL have port: clk  input  1  single clock, rising-edge active; all state changes on this edge.
REQ-005 The block SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port: write_enable  input  1  write strobe sampled at the rising edge.
REQ-007 The block SHALL have port: address_write  input  A_WIDTH  write word address.
REQ-008 The block SHALL have port: data_write  input  D_WIDTH  write data.
REQ-009 The block SHALL have port: address_read  input  A_WIDTH  read word address, read every cycle.
REQ-010 The block SHALL have port: data_read  output  D_WIDTH  registered read data.
REQ-011 The block SHALL have port: init_busy  output  1  high while the memory clear sequence runs.

Function
REQ-012 Storage: A_MAX words of D_WIDTH bits, inferable as block RAM; storage SHALL NOT be reset in one cycle.
REQ-013 Write: on a rising edge with write_enable=1, init_busy=0 and address_write<A_MAX, mem[address_write] <= data_write.
REQ-014 Read latency: exactly 1 cycle; data_read SHALL take mem[address_read] at each rising edge and hold it until the next edge.
REQ-015 Read-during-write to the same address in the same cycle SHALL return the new data_write value (write-first bypass).
REQ-016 Out of range: a write with address_write>=A_MAX SHALL be ignored; a read with address_read>=A_MAX SHALL load data_read with 0.
REQ-017 Clear sequencer: after rst deasserts, one word per cycle SHALL be written with 0, addresses 0..A_MAX-1 ascending, taking A_MAX cycles; init_busy SHALL be 1 during these cycles and 0 afterwards.
REQ-018 While init_busy=1, writes SHALL be ignored and data_read SHALL load 0.
REQ-019 Reads and writes to different addresses in the same cycle SHALL be independent.

Reset
REQ-020 While rst=1 at a rising edge: data_read <= 0, init_busy <= 1, and the clear pointer <= 0; writes are ignored.
REQ-021 rst asserted mid-sequence or mid-operation SHALL restart the full clear sequence from address 0.
REQ-022 rst has priority over every other input.

Configuration
REQ-023 Macro RAM_PARITY_EN: when defined, each word SHALL store an extra even-parity bit computed at write time, including 0 for cleared words.
REQ-024 With RAM_PARITY_EN defined, the block SHALL add output parity_error (1 bit, registered, aligned with data_read), set to 1 when the stored parity mismatches the read word; reset and out-of-range reads SHALL give 0.
REQ-025 Without RAM_PARITY_EN, the block SHALL have no parity storage and no parity_error port.

Verification
REQ-026 Params (8,5,32): pulse rst, wait init_busy=0, read 0x1B -> data_read=0x00 one cycle later.
REQ-027 Write 0xC5 to 0x1B, then read 0x1B -> data_read=0xC5 after 1 cycle.
REQ-028 Same cycle write 0x3A to 0x04 and read 0x04 -> data_read=0x3A at that edge.
REQ-029 Params (8,5,24): write 0xFF to 0x1B, read 0x1B -> 0x00; read 0x17 after writing 0x11 there -> 0x11.
REQ-030 Assert rst for 1 cycle after writing 0xC5 to 0x1B -> init_busy=1 for 32 cycles, then read 0x1B -> 0x00; a write during busy is lost.
REQ-031 RAM_PARITY_EN: write 0xC5 to 0x1B, force-flip a stored data bit, read 0x1B -> parity_error=1; an unflipped word -> 0.
